ibex_rvfi_tx: RTL and testbench
===============================

// Module: ibex_rvfi_tx
// PURPOSE
//  Producer end of the RVFI retirement trace consumed by the formal property checkers.
//  Captures per-instruction operand data at ID issue and holds it in order in a small FIFO.
//  Emits one registered RVFI record per writeback completion, with its result attached.
//  Sits inside ibex_core between the ID/WB stages and the rvfi_* outputs.
// PARAMETERS
//  DEPTH      2   in-flight entries (issued, not yet written back); power of two, >=2
//  ORDER_W    64  width of rvfi_order retirement counter
// PORTS
//  clk_i           in   1   clock
//  rst_i           in   1   synchronous reset, active-high
//  id_valid_i      in   1   ID issues an instruction this cycle
//  id_ready_o      out  1   entry available; issue accepted only when valid&&ready
//  id_insn_i       in   32  instruction word
//  id_rs1_rdata_i  in   32  rs1 value read at issue
//  id_rs2_rdata_i  in   32  rs2 value read at issue
//  wb_done_i       in   1   oldest in-flight instruction completes writeback
//  wb_rd_we_i      in   1   completion writes the register file
//  wb_rd_wdata_i   in   32  value written
//  flush_i         in   1   discard all in-flight entries not completing this cycle
//  rvfi_valid      out  1   one-cycle retirement pulse
//  rvfi_order      out  ORDER_W  retirement index, 0 for first retired insn
//  rvfi_insn       out  32  retired instruction word
//  rvfi_rs1_addr   out  5   insn[19:15]
//  rvfi_rs2_addr   out  5   insn[24:20]
//  rvfi_rs1_rdata  out  32  0 when rs1_addr==0, else captured value
//  rvfi_rs2_rdata  out  32  0 when rs2_addr==0, else captured value
//  rvfi_rd_addr    out  5   insn[11:7] if wb_rd_we_i else 0
//  rvfi_rd_wdata   out  32  wb_rd_wdata_i if rvfi_rd_addr!=0 else 0
//  tx_err_o        out  1   sticky: wb_done_i with FIFO empty and no same-cycle push
// BEHAVIOUR
//  - Reset: all rvfi_* outputs 0, rvfi_order 0, FIFO empty, id_ready_o 1, tx_err_o 0.
//  - Push on id_valid_i&&id_ready_o: entry {insn, rs1_rdata, rs2_rdata} at tail.
//  - id_ready_o = !full || wb_done_i (pop frees slot same cycle); combinational.
//  - Pop on wb_done_i: head entry + wb_* fields registered; rvfi_valid high the NEXT cycle
//    (latency 1), for exactly one cycle; other rvfi_* hold last record while valid low.
//  - Empty + simultaneous push and wb_done_i: bypass, record uses incoming ID data; no error.
//  - wb_done_i with empty FIFO and no push: no record emitted, tx_err_o set until reset.
//  - rvfi_order increments by 1 per emitted record; wraps modulo 2^ORDER_W silently.
//  - flush_i: pointers reset to empty; a same-cycle wb_done_i still retires the head;
//    a same-cycle push is dropped (flush wins over issue).
//  - Pointers log2(DEPTH)+1 bits; full = MSBs differ, low bits equal.
//  - Reset mid-operation: in-flight entries lost, pending rvfi_valid suppressed.
// CONFIGURATION
//  RVFI_TX_SVA_EN defined: embedded assertions - no push when full, no pop when empty
//   (except bypass), rvfi_valid never two consecutive cycles unless wb_done_i was high on
//   both preceding cycles, rvfi_order strictly +1 between records.
//  Not defined: no assertion code elaborated; RTL behaviour identical.
// STRUCTURE
//  ibex_rvfi_pkg: rvfi_entry_t {insn, rs1_rdata, rs2_rdata}, RVFI_XLEN=32,
//   insn field slice constants (RS1_LSB=15, RS2_LSB=20, RD_LSB=7).
//  Sub-module rvfi_tx_fifo: DEPTH-entry synchronous FIFO of rvfi_entry_t with flush.
// TESTING
//  1 Reset then idle 10 cycles -> rvfi_valid 0, rvfi_order 0, id_ready_o 1.
//  2 Issue 0xFFD08293 (addi x5,x1,-3) rs1=0x10; next cycle wb_done, we=1, wdata=0x0D
//    -> cycle after: rvfi_valid 1, rd_addr 5, rd_wdata 0x0D, rs1_addr 1, order 0.
//  3 Issue 3 insns back-to-back, no wb (DEPTH=2) -> id_ready_o 0 on third; with wb_done
//    same cycle -> third accepted; three records later have order 0,1,2 in issue order.
//  4 Issue addi x0,x0,0 (0x00000013), wb we=1 wdata=0x55 -> rd_addr 0, rd_wdata 0.
//  5 Two in flight, flush_i with wb_done_i -> one record (oldest); next wb_done_i on empty
//    -> no record, tx_err_o 1.
//  6 Set rvfi_order to 2^64-1 via forced state; one retire -> rvfi_order 0.

Source files
------------

// File: rtl/ibex_rvfi_pkg.sv
// ibex_rvfi_pkg
//   Shared types and constants for the RVFI trace producer (ibex_rvfi_tx) and
//   its operand FIFO (rvfi_tx_fifo).
//   rvfi_entry_t : operand snapshot taken when ID issues an instruction
//   *_LSB        : bit positions of the register fields in a 32-bit instruction
package ibex_rvfi_pkg;

  localparam int RVFI_XLEN  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int RD_LSB     = 7;

  typedef struct packed {
    logic [RVFI_XLEN-1:0] insn;
    logic [RVFI_XLEN-1:0] rs1_rdata;
    logic [RVFI_XLEN-1:0] rs2_rdata;
  } rvfi_entry_t;

  function automatic logic [REG_ADDR_W-1:0] insn_reg(input logic [RVFI_XLEN-1:0] insn,
                                                     input int lsb);
    return insn[lsb +: REG_ADDR_W];
  endfunction

endpackage

// File: rtl/rvfi_tx_fifo.sv
// rvfi_tx_fifo
//   In-order store of issued-but-not-retired instruction snapshots.
//   Ports:
//     clk_i, rst_i  clock, synchronous active-high reset
//     flush_i       empties the FIFO; a same-cycle push is discarded
//     push_i        write entry_i at the tail
//     entry_i       operand snapshot to store
//     pop_i         advance the head (caller guarantees not empty)
//     head_o        oldest entry, valid while empty_o is low
//     empty_o       no entries held
//     full_o        DEPTH entries held
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
module rvfi_tx_fifo
  import ibex_rvfi_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  rvfi_entry_t entry_i,
  input  logic        pop_i,
  output rvfi_entry_t head_o,
  output logic        empty_o,
  output logic        full_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  rvfi_entry_t      mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/ibex_rvfi_tx.sv
// ibex_rvfi_tx
//   Producer end of the RVFI retirement trace. Operands are snapshotted when ID
//   issues, held in order in rvfi_tx_fifo, and turned into one registered RVFI
//   record per writeback completion (rvfi_valid one cycle after wb_done_i).
//   Ports:
//     clk_i, rst_i        clock, synchronous active-high reset
//     id_valid_i/_ready_o issue handshake; id_insn_i, id_rs1/rs2_rdata_i operands
//     wb_done_i           oldest in-flight instruction completes writeback
//     wb_rd_we_i/_wdata_i register-file write of that completion
//     flush_i             drop all in-flight entries not completing this cycle
//     rvfi_*              registered retirement record
//     tx_err_o            sticky: completion seen with nothing in flight
//   Configuration:
//     RVFI_TX_SVA_EN      when defined, elaborates embedded protocol assertions
module ibex_rvfi_tx
  import ibex_rvfi_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int ORDER_W = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_valid_i,
  output logic               id_ready_o,
  input  logic [31:0]        id_insn_i,
  input  logic [31:0]        id_rs1_rdata_i,
  input  logic [31:0]        id_rs2_rdata_i,
  input  logic               wb_done_i,
  input  logic               wb_rd_we_i,
  input  logic [31:0]        wb_rd_wdata_i,
  input  logic               flush_i,
  output logic               rvfi_valid,
  output logic [ORDER_W-1:0] rvfi_order,
  output logic [31:0]        rvfi_insn,
  output logic [4:0]         rvfi_rs1_addr,
  output logic [4:0]         rvfi_rs2_addr,
  output logic [31:0]        rvfi_rs1_rdata,
  output logic [31:0]        rvfi_rs2_rdata,
  output logic [4:0]         rvfi_rd_addr,
  output logic [31:0]        rvfi_rd_wdata,
  output logic               tx_err_o
);

  rvfi_entry_t        id_entry;
  rvfi_entry_t        head;
  rvfi_entry_t        rec;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_push;
  logic               fifo_pop;
  logic               bypass;
  logic               retire;
  logic               orphan_wb;
  logic [4:0]         rec_rs1_addr;
  logic [4:0]         rec_rs2_addr;
  logic [4:0]         rec_rd_addr;
  logic [ORDER_W-1:0] order_cnt_q;

  assign id_entry = '{insn: id_insn_i, rs1_rdata: id_rs1_rdata_i, rs2_rdata: id_rs2_rdata_i};

  // A pop frees a slot in the same cycle, so a full FIFO still accepts issue.
  assign id_ready_o = !fifo_full || wb_done_i;

  // Empty FIFO with issue and completion together: the record is built straight
  // from the ID operands and nothing is stored. It retires even under flush,
  // since flush only discards entries that are not completing.
  assign bypass    = wb_done_i && fifo_empty && id_valid_i;
  assign fifo_pop  = wb_done_i && !fifo_empty;
  assign retire    = fifo_pop || bypass;
  assign orphan_wb = wb_done_i && fifo_empty && !id_valid_i;
  assign fifo_push = id_valid_i && id_ready_o && !bypass;

  rvfi_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (fifo_push),
    .entry_i (id_entry),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign rec          = bypass ? id_entry : head;
  assign rec_rs1_addr = insn_reg(rec.insn, RS1_LSB);
  assign rec_rs2_addr = insn_reg(rec.insn, RS2_LSB);
  assign rec_rd_addr  = wb_rd_we_i ? insn_reg(rec.insn, RD_LSB) : 5'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvfi_valid     <= 1'b0;
      rvfi_order     <= '0;
      rvfi_insn      <= '0;
      rvfi_rs1_addr  <= '0;
      rvfi_rs2_addr  <= '0;
      rvfi_rs1_rdata <= '0;
      rvfi_rs2_rdata <= '0;
      rvfi_rd_addr   <= '0;
      rvfi_rd_wdata  <= '0;
      tx_err_o       <= 1'b0;
      order_cnt_q    <= '0;
    end else begin
      rvfi_valid <= retire;
      if (orphan_wb) tx_err_o <= 1'b1;
      if (retire) begin
        rvfi_order     <= order_cnt_q;
        order_cnt_q    <= order_cnt_q + ORDER_W'(1);
        rvfi_insn      <= rec.insn;
        rvfi_rs1_addr  <= rec_rs1_addr;
        rvfi_rs2_addr  <= rec_rs2_addr;
        rvfi_rs1_rdata <= (rec_rs1_addr == 5'd0) ? 32'd0 : rec.rs1_rdata;
        rvfi_rs2_rdata <= (rec_rs2_addr == 5'd0) ? 32'd0 : rec.rs2_rdata;
        rvfi_rd_addr   <= rec_rd_addr;
        rvfi_rd_wdata  <= (rec_rd_addr == 5'd0) ? 32'd0 : wb_rd_wdata_i;
      end
    end
  end

`ifdef RVFI_TX_SVA_EN
  logic [ORDER_W-1:0] last_order_q;
  logic               seen_rec_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_order_q <= '0;
      seen_rec_q   <= 1'b0;
    end else if (rvfi_valid) begin
      last_order_q <= rvfi_order;
      seen_rec_q   <= 1'b1;
    end
  end

  a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_push && !flush_i |-> !fifo_full || fifo_pop);

  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (rst_i)
    wb_done_i |-> !fifo_empty || bypass);

  a_valid_b2b : assert property (@(posedge clk_i) disable iff (rst_i)
    rvfi_valid && $past(rvfi_valid) |-> $past(wb_done_i, 1) && $past(wb_done_i, 2));

  a_order_step : assert property (@(posedge clk_i) disable iff (rst_i)
    rvfi_valid && seen_rec_q |-> rvfi_order == last_order_q + ORDER_W'(1));
`endif

endmodule

// File: tb/tb_ibex_rvfi_tx.sv
module tb_ibex_rvfi_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_insn = '0;
  logic [31:0] id_rs1 = '0;
  logic [31:0] id_rs2 = '0;
  logic        wb_done = 1'b0;
  logic        wb_we = 1'b0;
  logic [31:0] wb_wdata = '0;
  logic        flush = 1'b0;

  logic        id_ready, rv_valid, tx_err;
  logic [63:0] rv_order;
  logic [31:0] rv_insn, rv_rs1d, rv_rs2d, rv_rdd;
  logic [4:0]  rv_rs1a, rv_rs2a, rv_rda;

  // Second instance with a 3-bit order counter to exercise wrap-around.
  logic        id_ready2, rv_valid2, tx_err2;
  logic [2:0]  rv_order2;
  logic [31:0] rv_insn2, rv_rs1d2, rv_rs2d2, rv_rdd2;
  logic [4:0]  rv_rs1a2, rv_rs2a2, rv_rda2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ibex_rvfi_tx #(.DEPTH(2), .ORDER_W(64)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_insn_i(id_insn), .id_rs1_rdata_i(id_rs1), .id_rs2_rdata_i(id_rs2),
    .wb_done_i(wb_done), .wb_rd_we_i(wb_we), .wb_rd_wdata_i(wb_wdata), .flush_i(flush),
    .rvfi_valid(rv_valid), .rvfi_order(rv_order), .rvfi_insn(rv_insn),
    .rvfi_rs1_addr(rv_rs1a), .rvfi_rs2_addr(rv_rs2a), .rvfi_rs1_rdata(rv_rs1d),
    .rvfi_rs2_rdata(rv_rs2d), .rvfi_rd_addr(rv_rda), .rvfi_rd_wdata(rv_rdd),
    .tx_err_o(tx_err)
  );

  ibex_rvfi_tx #(.DEPTH(2), .ORDER_W(3)) dut_w (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ready_o(id_ready2),
    .id_insn_i(id_insn), .id_rs1_rdata_i(id_rs1), .id_rs2_rdata_i(id_rs2),
    .wb_done_i(wb_done), .wb_rd_we_i(wb_we), .wb_rd_wdata_i(wb_wdata), .flush_i(flush),
    .rvfi_valid(rv_valid2), .rvfi_order(rv_order2), .rvfi_insn(rv_insn2),
    .rvfi_rs1_addr(rv_rs1a2), .rvfi_rs2_addr(rv_rs2a2), .rvfi_rs1_rdata(rv_rs1d2),
    .rvfi_rs2_rdata(rv_rs2d2), .rvfi_rd_addr(rv_rda2), .rvfi_rd_wdata(rv_rdd2),
    .tx_err_o(tx_err2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] insn;
    logic [31:0] a;
    logic [31:0] b;
  } ent_t;

  ent_t        q[$];
  logic        m_valid = 1'b0;
  logic [63:0] m_order = '0;
  logic [63:0] m_next = '0;
  logic [31:0] m_insn = '0, m_rs1d = '0, m_rs2d = '0, m_rdd = '0;
  logic [4:0]  m_rs1a = '0, m_rs2a = '0, m_rda = '0;
  logic        m_err = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_valid = 0; m_order = 0; m_next = 0; m_insn = 0;
        m_rs1a = 0; m_rs2a = 0; m_rs1d = 0; m_rs2d = 0; m_rda = 0; m_rdd = 0;
        m_err = 0;
      end else begin
        automatic bit   ready = (q.size() < 2) || wb_done;
        automatic bit   have = 0;
        automatic bit   byp = 0;
        automatic ent_t rec = '{insn: id_insn, a: id_rs1, b: id_rs2};
        if (wb_done) begin
          if (q.size() > 0) begin
            rec = q.pop_front();
            have = 1;
          end else if (id_valid) begin
            have = 1;
            byp = 1;
          end else begin
            m_err = 1;
          end
        end
        if (id_valid && ready && !byp && !flush)
          q.push_back('{insn: id_insn, a: id_rs1, b: id_rs2});
        if (flush) q.delete();
        m_valid = have;
        if (have) begin
          m_order = m_next;
          m_next  = m_next + 1;
          m_insn  = rec.insn;
          m_rs1a  = rec.insn[19:15];
          m_rs2a  = rec.insn[24:20];
          m_rs1d  = (m_rs1a == 0) ? 32'd0 : rec.a;
          m_rs2d  = (m_rs2a == 0) ? 32'd0 : rec.b;
          m_rda   = wb_we ? rec.insn[11:7] : 5'd0;
          m_rdd   = (m_rda == 0) ? 32'd0 : wb_wdata;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("id_ready", {63'd0, id_ready}, {63'd0, (q.size() < 2) || wb_done});
        chk("rvfi_valid", {63'd0, rv_valid}, {63'd0, m_valid});
        chk("tx_err", {63'd0, tx_err}, {63'd0, m_err});
        chk("rvfi_order", rv_order, m_order);
        chk("rvfi_insn", {32'd0, rv_insn}, {32'd0, m_insn});
        chk("rvfi_rs_addr", {54'd0, rv_rs1a, rv_rs2a}, {54'd0, m_rs1a, m_rs2a});
        chk("rvfi_rs_rdata", {rv_rs1d, rv_rs2d}, {m_rs1d, m_rs2d});
        chk("rvfi_rd", {27'd0, rv_rda, rv_rdd}, {27'd0, m_rda, m_rdd});
        chk("wrap_order", {61'd0, rv_order2}, {61'd0, m_order[2:0]});
        chk("wrap_rest",
            {8'd0, id_ready2, rv_valid2, tx_err2, rv_rs1a2, rv_rs2a2, rv_rda2, rv_insn2[31:0]} ^
            {32'd0, rv_rs1d2 ^ rv_rs2d2 ^ rv_rdd2},
            {8'd0, id_ready, rv_valid, tx_err, rv_rs1a, rv_rs2a, rv_rda, rv_insn} ^
            {32'd0, rv_rs1d ^ rv_rs2d ^ rv_rdd});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic v, input logic [31:0] insn, input logic [31:0] a,
                     input logic [31:0] b, input logic wb, input logic we,
                     input logic [31:0] wd, input logic fl);
    id_valid = v; id_insn = insn; id_rs1 = a; id_rs2 = b;
    wb_done = wb; wb_we = we; wb_wdata = wd; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();

    // 1: idle after reset
    idle(10);
    chk("t1_valid", {63'd0, rv_valid}, 64'd0);
    chk("t1_order", rv_order, 64'd0);
    chk("t1_ready", {63'd0, id_ready}, 64'd1);

    // 2: addi x5,x1,-3
    cyc(1, 32'hFFD08293, 32'h10, 32'h22, 0, 0, 32'h0, 0);
    cyc(0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h0D, 0);
    chk("t2_valid", {63'd0, rv_valid}, 64'd1);
    chk("t2_rd_addr", {59'd0, rv_rda}, 64'd5);
    chk("t2_rd_wdata", {32'd0, rv_rdd}, 64'h0D);
    chk("t2_rs1_addr", {59'd0, rv_rs1a}, 64'd1);
    chk("t2_rs1_rdata", {32'd0, rv_rs1d}, 64'h10);
    chk("t2_rs2_addr", {59'd0, rv_rs2a}, 64'd29);
    chk("t2_order", rv_order, 64'd0);
    idle(1);
    chk("t2_pulse", {63'd0, rv_valid}, 64'd0);
    chk("t2_hold", {59'd0, rv_rda}, 64'd5);

    // 3: fill, back-pressure, accept with pop
    do_reset();
    cyc(1, 32'h00208033, 32'h1, 32'h2, 0, 0, 32'h0, 0);
    cyc(1, 32'h004180B3, 32'h3, 32'h4, 0, 0, 32'h0, 0);
    id_valid = 1; id_insn = 32'h00628133; wb_done = 0;
    #1;
    chk("t3_ready_full", {63'd0, id_ready}, 64'd0);
    @(posedge clk); #1;
    cyc(1, 32'h00628133, 32'h5, 32'h6, 1, 1, 32'hA0, 0);
    chk("t3_rec0_insn", {32'd0, rv_insn}, 64'h00208033);
    chk("t3_rec0_order", rv_order, 64'd0);
    cyc(0, 32'h0, 32'h0, 32'h0, 1, 1, 32'hA1, 0);
    chk("t3_rec1_insn", {32'd0, rv_insn}, 64'h004180B3);
    chk("t3_rec1_order", rv_order, 64'd1);
    cyc(0, 32'h0, 32'h0, 32'h0, 1, 1, 32'hA2, 0);
    chk("t3_rec2_insn", {32'd0, rv_insn}, 64'h00628133);
    chk("t3_rec2_order", rv_order, 64'd2);
    chk("t3_rec2_rs2", {32'd0, rv_rs2d}, 64'h6);
    idle(2);

    // 4: nop writing x0
    cyc(1, 32'h00000013, 32'h77, 32'h88, 0, 0, 32'h0, 0);
    cyc(0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h55, 0);
    chk("t4_valid", {63'd0, rv_valid}, 64'd1);
    chk("t4_rd_addr", {59'd0, rv_rda}, 64'd0);
    chk("t4_rd_wdata", {32'd0, rv_rdd}, 64'd0);
    chk("t4_rs1_rdata", {32'd0, rv_rs1d}, 64'd0);

    // 5: flush with completion, then orphan completion
    do_reset();
    cyc(1, 32'h00A00093, 32'h1, 32'h0, 0, 0, 32'h0, 0);
    cyc(1, 32'h00B00113, 32'h2, 32'h0, 0, 0, 32'h0, 0);
    cyc(0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h0A, 1);
    chk("t5_valid", {63'd0, rv_valid}, 64'd1);
    chk("t5_insn", {32'd0, rv_insn}, 64'h00A00093);
    cyc(0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h0B, 0);
    chk("t5_no_rec", {63'd0, rv_valid}, 64'd0);
    chk("t5_err", {63'd0, tx_err}, 64'd1);
    idle(3);
    chk("t5_err_sticky", {63'd0, tx_err}, 64'd1);

    // reset mid-operation suppresses the pending record
    do_reset();
    cyc(1, 32'h00C00193, 32'h3, 32'h0, 0, 0, 32'h0, 0);
    rst = 1'b1;
    cyc(0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h0C, 0);
    rst = 1'b0;
    chk("rst_valid", {63'd0, rv_valid}, 64'd0);
    chk("rst_err", {63'd0, tx_err}, 64'd0);
    idle(2);

    // 6: order wrap via the 3-bit instance, bypass retire every cycle
    do_reset();
    for (int i = 0; i < 9; i++)
      cyc(1, 32'h00100013 + (i << 7), 32'(i), 32'(i + 1), 1, 1, 32'(i + 100), 0);
    chk("t6_order", rv_order, 64'd8);
    chk("t6_wrap", {61'd0, rv_order2}, 64'd0);
    chk("t6_err", {63'd0, tx_err}, 64'd0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
